// File: rtl/hilbert_pkg.sv
// ---------------------------------------------------------------------------
// hilbert_pkg
// Shared constants and helpers for the multi-channel Hilbert IQ converter.
//   chw_of(ch)          : channel tag width, never narrower than one bit
//   accw_of(dw, cw)     : accumulator width for the odd-tap product sum
//   taps_legal(taps)    : odd length whose centre offset is itself odd
//   hilbert_coef(t, k)  : Q8 coefficient C[k] for odd k <= (t-1)/2
//   coef_abs_sum(t)     : sum of |C[k]|, kept below 2^FRAC so the
//                         rounded output always fits in DW+1 bits
// ---------------------------------------------------------------------------
package hilbert_pkg;

    function automatic int chw_of(input int ch);
        return (ch <= 2) ? 1 : $clog2(ch);
    endfunction

    function automatic int accw_of(input int dw, input int cw);
        return dw + cw + 4;
    endfunction

    function automatic bit taps_legal(input int taps);
        return (taps >= 3) && ((taps % 2) == 1) && ((((taps - 1) / 2) % 2) == 1);
    endfunction

    // Windowed ideal Hilbert taps 2/(pi*k), quantised to Q8. Only odd k
    // carry weight; the antisymmetry is applied by the datapath, so only
    // one side of the impulse response is stored.
    function automatic int hilbert_coef(input int taps, input int k);
        int c;
        c = 0;
        case (taps)
            3: begin
                if (k == 1) c = 128;
            end
            7: begin
                case (k)
                    1:       c = 160;
                    3:       c = 61;
                    default: c = 0;
                endcase
            end
            11: begin
                case (k)
                    1:       c = 163;
                    3:       c = 62;
                    5:       c = 25;
                    default: c = 0;
                endcase
            end
            default: c = 0;
        endcase
        return c;
    endfunction

    function automatic int coef_abs_sum(input int taps);
        int s;
        int v;
        s = 0;
        for (int k = 1; k <= (taps - 1) / 2; k += 2) begin
            v = hilbert_coef(taps, k);
            s += (v < 0) ? -v : v;
        end
        return s;
    endfunction

endpackage

// File: rtl/hilbert_chan_mem.sv
// ---------------------------------------------------------------------------
// hilbert_chan_mem
// CH x TAPS delay-line store. Every cycle the line of channel 'ch' is read,
// shifted by one with 'x' entering at d[0] (or with the old contents
// dropped when 'clear' is high) and presented on 'shifted'. When 'wr_en'
// is high the shifted line is written back.
// The write-back goes through a one-entry staging register before it lands
// in the array, so a same-channel sample on the very next cycle is served
// from the staging register instead of the not-yet-updated array.
//   clock, reset_n : clock, synchronous active-low reset (clears all lines)
//   wr_en          : accept the sample (channel already range checked)
//   clear          : treat the old line as all zero
//   ch, x          : channel and sample
//   shifted        : d[0..TAPS-1] of 'ch' including the new sample
// ---------------------------------------------------------------------------
module hilbert_chan_mem #(
    parameter int DW   = 12,
    parameter int CH   = 4,
    parameter int TAPS = 7,
    parameter int CHW  = 2
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       wr_en,
    input  logic                       clear,
    input  logic [CHW-1:0]             ch,
    input  logic [DW-1:0]              x,
    output logic [TAPS-1:0][DW-1:0]    shifted
);

    logic [TAPS-1:0][DW-1:0] mem [CH];
    logic                    wb_valid;
    logic [CHW-1:0]          wb_ch;
    logic [TAPS-1:0][DW-1:0] wb_line;
    logic [TAPS-1:0][DW-1:0] cur;
    logic                    unused_oldest;

    // Pick the freshest copy of the channel's line: the staged write-back
    // if it belongs to this channel, otherwise the array. Then shift in x.
    always_comb begin
        cur = '0;
        if (wb_valid && (wb_ch == ch)) begin
            cur = wb_line;
        end else if (32'(ch) < CH) begin
            cur = mem[ch];
        end
        shifted    = '0;
        shifted[0] = x;
        for (int i = 1; i < TAPS; i++) begin
            shifted[i] = clear ? '0 : cur[i-1];
        end
    end

    // The oldest sample falls off the end of the line by design.
    assign unused_oldest = ^cur[TAPS-1];

    // Commit last cycle's staged line to the array and stage the new one.
    // Reset wipes both, which also drops any write still in flight.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int c = 0; c < CH; c++) begin
                mem[c] <= '0;
            end
            wb_valid <= 1'b0;
            wb_ch    <= '0;
            wb_line  <= '0;
        end else begin
            if (wb_valid) begin
                mem[wb_ch] <= wb_line;
            end
            wb_valid <= wr_en;
            if (wr_en) begin
                wb_ch   <= ch;
                wb_line <= shifted;
            end
        end
    end

endmodule

// File: rtl/hilbert_iq_mc.sv
// ---------------------------------------------------------------------------
// hilbert_iq_mc
// Time-multiplexed real-to-analytic converter. Each channel runs an odd
// antisymmetric FIR Hilbert transformer; Re is the centre tap so it is
// group-delay aligned with Im. Fixed latency of two clocks, one sample per
// clock, no backpressure.
//   clock, reset_n  : clock, synchronous active-low reset
//   in_valid        : sample strobe
//   in_ch           : channel of in_x (codes >= CH are dropped)
//   in_x            : signed sample, DW bits
//   ch_clear        : with in_valid, zero in_ch's line before writing in_x
//   out_valid       : one-cycle result strobe
//   out_ch          : channel of the result
//   out_re, out_im  : signed DW+1 bit results, held while out_valid is low
// Build option HILBERT_FILL_MASK_EN: suppress results until a channel has
// taken TAPS samples since reset or its last clear.
// ---------------------------------------------------------------------------
module hilbert_iq_mc
    import hilbert_pkg::*;
#(
    parameter int DW   = 12,
    parameter int CH   = 4,
    parameter int TAPS = 7,
    parameter int CW   = 9,
    parameter int FRAC = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       in_valid,
    input  logic [chw_of(CH)-1:0]      in_ch,
    input  logic signed [DW-1:0]       in_x,
    input  logic                       ch_clear,
    output logic                       out_valid,
    output logic [chw_of(CH)-1:0]      out_ch,
    output logic signed [DW:0]         out_re,
    output logic signed [DW:0]         out_im
);

    localparam int CHW  = chw_of(CH);
    localparam int C    = (TAPS - 1) / 2;
    localparam int NK   = (C + 1) / 2;
    localparam int PW   = DW + 1 + CW;
    localparam int ACCW = accw_of(DW, CW);
    localparam logic signed [ACCW-1:0] HALF = ACCW'(2 ** (FRAC - 1));

    if (!taps_legal(TAPS)) begin : g_bad_taps
        $error("hilbert_iq_mc: TAPS must be odd with an odd centre offset");
    end
    if (hilbert_coef(TAPS, 1) == 0) begin : g_no_table
        $error("hilbert_iq_mc: no coefficient table for this TAPS");
    end
    if (coef_abs_sum(TAPS) >= (2 ** FRAC)) begin : g_coef_sum
        $error("hilbert_iq_mc: coefficient magnitude sum could overflow");
    end

    logic                    accept;
    logic                    emit;
    logic [TAPS-1:0][DW-1:0] shifted;
    logic                    unused_taps;

    assign accept = in_valid && (32'(in_ch) < CH);

    hilbert_chan_mem #(
        .DW   (DW),
        .CH   (CH),
        .TAPS (TAPS),
        .CHW  (CHW)
    ) u_mem (
        .clock   (clock),
        .reset_n (reset_n),
        .wr_en   (accept),
        .clear   (ch_clear),
        .ch      (in_ch),
        .x       (in_x),
        .shifted (shifted)
    );

    // Even-offset taps other than the centre carry zero weight.
    assign unused_taps = ^shifted;

`ifdef HILBERT_FILL_MASK_EN
    localparam int FW = $clog2(TAPS + 1);
    logic [FW-1:0] fill [CH];
    logic [FW-1:0] fill_cur;
    logic [FW-1:0] fill_next;

    // A clear restarts the count, and the clearing sample is the first one
    // of the new fill. Only the sample that completes the fill, and every
    // one after it, is allowed to emit.
    always_comb begin
        fill_cur  = ch_clear ? '0 : fill[in_ch];
        fill_next = (fill_cur == FW'(TAPS)) ? fill_cur : fill_cur + FW'(1);
        emit      = accept && (fill_next == FW'(TAPS));
    end

    // Per-channel saturating fill counters.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int c = 0; c < CH; c++) begin
                fill[c] <= '0;
            end
        end else if (accept) begin
            fill[in_ch] <= fill_next;
        end
    end
`else
    assign emit = accept;
`endif

    logic signed [PW-1:0] prod_c [NK];
    logic signed [PW-1:0] prod_q [NK];

    for (genvar j = 0; j < NK; j++) begin : g_tap
        localparam int K = 2 * j + 1;
        localparam logic signed [CW-1:0] COEF = CW'(hilbert_coef(TAPS, K));
        logic signed [DW:0]   diff;
        logic signed [PW-1:0] diff_x;
        logic signed [PW-1:0] coef_x;
        assign diff      = $signed({shifted[C+K][DW-1], shifted[C+K]})
                         - $signed({shifted[C-K][DW-1], shifted[C-K]});
        assign diff_x    = {{(PW-DW-1){diff[DW]}}, diff};
        assign coef_x    = {{(PW-CW){COEF[CW-1]}}, COEF};
        assign prod_c[j] = diff_x * coef_x;
    end

    logic                s1_valid;
    logic [CHW-1:0]      s1_ch;
    logic [DW-1:0]       s1_re;

    // First pipeline register: tap-pair products plus the centre sample
    // and tag that travel alongside them.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_ch    <= '0;
            s1_re    <= '0;
            for (int j = 0; j < NK; j++) begin
                prod_q[j] <= '0;
            end
        end else begin
            s1_valid <= emit;
            if (accept) begin
                s1_ch <= in_ch;
                s1_re <= shifted[C];
                for (int j = 0; j < NK; j++) begin
                    prod_q[j] <= prod_c[j];
                end
            end
        end
    end

    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] biased;
    logic signed [DW:0]     im_round;

    // Sum the products and round half-up back to sample scale. The
    // coefficient bound keeps the result inside DW+1 bits, so the
    // truncation below never discards significant bits.
    always_comb begin
        acc = '0;
        for (int j = 0; j < NK; j++) begin
            acc = acc + {{(ACCW-PW){prod_q[j][PW-1]}}, prod_q[j]};
        end
        biased   = acc + HALF;
        im_round = (DW+1)'(biased >>> FRAC);
    end

    // Output register: strobe for one cycle, data held between results.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_re    <= '0;
            out_im    <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_ch <= s1_ch;
                out_re <= {s1_re[DW-1], s1_re};
                out_im <= im_round;
            end
        end
    end

endmodule

// File: tb/tb_hilbert_iq_mc.sv
// ---------------------------------------------------------------------------
// tb_hilbert_iq_mc
// Bench for hilbert_iq_mc with DW=12, TAPS=7 and three channels, so the
// two-bit channel field has an unused code (3). A per-channel delay-line
// model predicts every result two clocks after its sample; a negedge
// process compares strobe, tag and held data every cycle. Results are also
// logged and a set of hand-worked values is checked against that log.
// ---------------------------------------------------------------------------
module tb_hilbert_iq_mc;

    localparam int DW   = 12;
    localparam int CH   = 3;
    localparam int TAPS = 7;
    localparam int CW   = 9;
    localparam int FRAC = 8;
    localparam int CHW  = 2;
    localparam int CTR  = (TAPS - 1) / 2;

    localparam int IMP_IM [7] = '{-24, 0, -62, 0, 63, 0, 24};
    localparam int IMP_RE [7] = '{0, 0, 0, 100, 0, 0, 0};
    localparam int COEF   [4] = '{0, 160, 0, 61};

    logic                clock = 1'b0;
    logic                reset_n;
    logic                in_valid;
    logic [CHW-1:0]      in_ch;
    logic signed [DW-1:0] in_x;
    logic                ch_clear;
    logic                out_valid;
    logic [CHW-1:0]      out_ch;
    logic signed [DW:0]  out_re;
    logic signed [DW:0]  out_im;

    always #5 clock = ~clock;

    hilbert_iq_mc #(
        .DW   (DW),
        .CH   (CH),
        .TAPS (TAPS),
        .CW   (CW),
        .FRAC (FRAC)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ch     (in_ch),
        .in_x      (in_x),
        .ch_clear  (ch_clear),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_re    (out_re),
        .out_im    (out_im)
    );

    typedef struct {
        int due;
        int ch;
        int re;
        int im;
    } exp_t;

    typedef struct {
        int ch;
        int re;
        int im;
    } obs_t;

    exp_t pend[$];
    obs_t seen[$];
    int   line [CH][TAPS];
    int   fill [CH];
    int   cyc      = 0;
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   zero_at  = -1;
    bit   checking = 1'b0;
    bit   exp_v;
    int   last_ch  = 0;
    int   last_re  = 0;
    int   last_im  = 0;

    // Cycle counter, advanced on every rising edge.
    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_bad++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    // Hilbert output straight from the filter definition on the model line.
    function automatic int modelIm(input int ch);
        int acc;
        acc = 0;
        for (int k = 1; k <= CTR; k += 2) begin
            acc += COEF[k] * (line[ch][CTR+k] - line[ch][CTR-k]);
        end
        return (acc + (1 << (FRAC - 1))) >>> FRAC;
    endfunction

    task automatic clearModel();
        for (int c = 0; c < CH; c++) begin
            fill[c] = 0;
            for (int t = 0; t < TAPS; t++) line[c][t] = 0;
        end
    endtask

    // Drive one clock's worth of inputs and advance the model.
    task automatic applyStimulus(input bit v, input int ch, input int x, input bit clr);
        bit emit;
        @(posedge clock);
        #1;
        reset_n  = 1'b1;
        in_valid = v;
        in_ch    = CHW'(ch);
        in_x     = DW'(x);
        ch_clear = clr;
        if (v && ch < CH) begin
            if (clr) begin
                fill[ch] = 0;
                for (int t = 0; t < TAPS; t++) line[ch][t] = 0;
            end
            for (int t = TAPS - 1; t > 0; t--) line[ch][t] = line[ch][t-1];
            line[ch][0] = x;
            if (fill[ch] < TAPS) fill[ch]++;
            emit = 1'b1;
`ifdef HILBERT_FILL_MASK_EN
            emit = (fill[ch] == TAPS);
`endif
            if (emit) pend.push_back('{cyc + 2, ch, line[ch][CTR], modelIm(ch)});
        end
    endtask

    // One cycle of reset with a sample presented alongside it.
    task automatic pulseReset(input bit v, input int ch, input int x);
        @(posedge clock);
        #1;
        reset_n  = 1'b0;
        in_valid = v;
        in_ch    = CHW'(ch);
        in_x     = DW'(x);
        ch_clear = 1'b0;
        while (pend.size() > 0 && pend[pend.size()-1].due > cyc) pend.pop_back();
        zero_at = cyc + 1;
        clearModel();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 1'b0);
    endtask

    // Look up the nth logged result of a channel since 'base'.
    task automatic checkNth(input string name, input int base, input int ch, input int nth,
                            input int exp_re, input int exp_im);
        int hits;
        int idx;
        hits = 0;
        idx  = -1;
        for (int i = base; i < seen.size(); i++) begin
            if (seen[i].ch == ch) begin
                if (hits == nth) idx = i;
                hits++;
            end
        end
        checkOutput({name, ".present"}, int'(idx >= 0), 1);
        if (idx >= 0) begin
            checkOutput({name, ".re"}, seen[idx].re, exp_re);
            checkOutput({name, ".im"}, seen[idx].im, exp_im);
        end
    endtask

    // Per-cycle comparison of the DUT against the model.
    always @(negedge clock) begin
        if (checking) begin
            if (cyc == zero_at) begin
                last_ch = 0;
                last_re = 0;
                last_im = 0;
            end
            exp_v = (pend.size() > 0) && (pend[0].due == cyc);
            if (exp_v) begin
                last_ch = pend[0].ch;
                last_re = pend[0].re;
                last_im = pend[0].im;
                void'(pend.pop_front());
            end
            checkOutput("out_valid", int'(out_valid), int'(exp_v));
            checkOutput("out_ch", int'(out_ch), last_ch);
            checkOutput("out_re", int'(out_re), last_re);
            checkOutput("out_im", int'(out_im), last_im);
            if (out_valid) seen.push_back('{int'(out_ch), int'(out_re), int'(out_im)});
        end
    end

    initial begin
        int b_imp, b_ilv, b_fwd, b_str, b_inv, b_rst;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_ch    = '0;
        in_x     = '0;
        ch_clear = 1'b0;
        clearModel();
        repeat (2) @(posedge clock);
        #1;
        checking = 1'b1;

        $display("[TB] impulse on channel 0");
        b_imp = seen.size();
        applyStimulus(1'b1, 0, 100, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 0, 0, 1'b0);
        idle(3);

        $display("[TB] interleaved channels 0 and 1");
        b_ilv = seen.size();
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 0, (i == 0) ? 100 : 0, i == 0);
            applyStimulus(1'b1, 1, 500, i == 0);
        end
        idle(3);

        $display("[TB] back-to-back samples on channel 2");
        b_fwd = seen.size();
        applyStimulus(1'b1, 2, 2047, 1'b1);
        applyStimulus(1'b1, 2, -2048, 1'b0);
        applyStimulus(1'b1, 2, 2047, 1'b0);
        idle(3);

        $display("[TB] full-scale stress");
        b_str = seen.size();
        applyStimulus(1'b1, 2, -2048, 1'b1);
        applyStimulus(1'b1, 2, 0, 1'b0);
        applyStimulus(1'b1, 2, -2048, 1'b0);
        applyStimulus(1'b1, 2, 0, 1'b0);
        applyStimulus(1'b1, 2, 2047, 1'b0);
        applyStimulus(1'b1, 2, 0, 1'b0);
        applyStimulus(1'b1, 2, 2047, 1'b0);
        applyStimulus(1'b1, 2, 2047, 1'b1);
        applyStimulus(1'b1, 2, 0, 1'b0);
        applyStimulus(1'b1, 2, 2047, 1'b0);
        applyStimulus(1'b1, 2, 0, 1'b0);
        applyStimulus(1'b1, 2, -2048, 1'b0);
        applyStimulus(1'b1, 2, 0, 1'b0);
        applyStimulus(1'b1, 2, -2048, 1'b0);
        idle(3);

        $display("[TB] invalid channel, idle clear, mid-stream clear");
        b_inv = seen.size();
        applyStimulus(1'b1, 3, 1234, 1'b1);
        applyStimulus(1'b0, 1, 999, 1'b1);
        applyStimulus(1'b1, 2, 0, 1'b0);
        applyStimulus(1'b1, 1, 500, 1'b0);
        applyStimulus(1'b1, 1, 77, 1'b1);
        idle(3);

        $display("[TB] reset with samples in flight");
        applyStimulus(1'b1, 0, 300, 1'b0);
        pulseReset(1'b1, 1, 400);
        idle(4);
        b_rst = seen.size();
        applyStimulus(1'b1, 0, 100, 1'b0);
        applyStimulus(1'b1, 1, 100, 1'b0);
        idle(4);

`ifndef HILBERT_FILL_MASK_EN
        for (int n = 0; n < 7; n++) begin
            checkNth("impulse", b_imp, 0, n, IMP_RE[n], IMP_IM[n]);
            checkNth("ilv_ch0", b_ilv, 0, n, IMP_RE[n], IMP_IM[n]);
        end
        checkNth("ilv_ch1_partial", b_ilv, 1, 3, 500, -432);
        checkNth("ilv_ch1_filled", b_ilv, 1, 6, 500, 0);
        checkNth("fwd_0", b_fwd, 2, 0, 0, -488);
        checkNth("fwd_1", b_fwd, 2, 1, 0, 488);
        checkNth("fwd_2", b_fwd, 2, 2, 0, -1767);
        checkNth("stress_neg", b_str, 2, 6, 0, -3535);
        checkNth("stress_pos", b_str, 2, 13, 0, 3535);
        checkNth("after_bad_ch", b_inv, 2, 0, -2048, 0);
        checkNth("idle_clear", b_inv, 1, 0, 500, 0);
        checkNth("clear_mid", b_inv, 1, 1, 0, -18);
        checkNth("post_reset_ch0", b_rst, 0, 0, 0, -24);
        checkNth("post_reset_ch1", b_rst, 1, 0, 0, -24);
        checkOutput("reset_dropped", seen.size() - b_rst, 2);
`endif

        checkOutput("pending", pend.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
